hpu_vram_arb: RTL and testbench

HPU_VRAM_ARB -- requirements
Module: hpu_vram_arb

---
 rtl/hpu_vram_arb.sv | 129 ++++++++++++
 tb/tb_hpu_vram_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_vram_arb.sv
// VRAM arbiter: tile fetcher, sprite engine and CPU share one single-port VRAM.
// Winner is picked combinationally each cycle; owner tag routes the next cycle's read data.
module hpu_vram_arb #(
  parameter int CPU_STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tile_active,
  input  logic [15:0] tile_addr,
  output logic [7:0]  tile_data,
  input  logic        spr_req,
  input  logic [15:0] spr_addr,
  output logic        spr_gnt,
  output logic        spr_rvalid,
  output logic [7:0]  spr_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RDATA = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_TILE = 2'd1, OWN_SPR = 2'd2, OWN_CPU = 2'd3} owner_t;

  localparam logic [3:0] LIMIT = 4'(CPU_STARVE_LIMIT);

  state_t     r_state, w_state_nxt;
  owner_t     r_owner, w_win;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_cpu_ack, w_cpu_ack_nxt;
  logic [7:0] r_cpu_rdata;
  logic       w_cpu_elig, w_starved;

  // The CPU competes only before its grant; the RDATA and ack cycles ignore a still-held cpu_req.
  assign w_cpu_elig = cpu_req && !r_cpu_ack && (r_state == S_IDLE || r_state == S_WAIT);
  assign w_starved  = (r_cnt == LIMIT);

  always_comb begin
    w_win = OWN_NONE;
    if (reset)                       w_win = OWN_NONE;
    else if (tile_active)            w_win = OWN_TILE;
    else if (w_cpu_elig && w_starved) w_win = OWN_CPU;
    else if (spr_req)                w_win = OWN_SPR;
    else if (w_cpu_elig)             w_win = OWN_CPU;
  end

  always_comb begin
    mem_addr  = tile_addr;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    case (w_win)
      OWN_SPR: mem_addr = spr_addr;
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cpu_ack_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (w_cpu_elig) begin
          if (w_win == OWN_CPU) begin
            if (cpu_we) begin
              w_state_nxt   = S_IDLE;
              w_cpu_ack_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RDATA;
            end
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RDATA: begin
        w_state_nxt   = S_IDLE;
        w_cpu_ack_nxt = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counts sprite wins over a waiting CPU, so the CPU wins right after LIMIT sprite grants.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!cpu_req || w_win == OWN_CPU)
      w_cnt_nxt = 4'd0;
    else if (w_cpu_elig && w_win == OWN_SPR && r_cnt != LIMIT)
      w_cnt_nxt = r_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_cnt       <= 4'd0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_win;
      r_cnt     <= w_cnt_nxt;
      r_cpu_ack <= w_cpu_ack_nxt;
      if (r_state == S_RDATA)
        r_cpu_rdata <= mem_rdata;
    end
  end

  assign tile_data  = mem_rdata;
  assign spr_gnt    = (w_win == OWN_SPR);
  assign spr_rvalid = (r_owner == OWN_SPR);
  assign spr_rdata  = spr_rvalid ? mem_rdata : 8'h00;
  assign cpu_ack    = r_cpu_ack;
  assign cpu_rdata  = r_cpu_rdata;

endmodule

// File: tb/tb_hpu_vram_arb.sv
// Bench for hpu_vram_arb: VRAM device model, cycle reference model of the arbitration
// rules, and a scoreboard monitor for sprite read data and CPU completions.
module tb_hpu_vram_arb;
  localparam int LIMIT  = 8;
  localparam int W_NONE = 0, W_TILE = 1, W_SPR = 2, W_CPU = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tile_active = 1'b0;
  logic [15:0] tile_addr = '0;
  logic [7:0]  tile_data;
  logic        spr_req = 1'b0;
  logic [15:0] spr_addr = '0;
  logic        spr_gnt, spr_rvalid;
  logic [7:0]  spr_rdata;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  always #5 clk = ~clk;

  hpu_vram_arb #(.CPU_STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .tile_active(tile_active), .tile_addr(tile_addr), .tile_data(tile_data),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt),
    .spr_rvalid(spr_rvalid), .spr_rdata(spr_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Power-up VRAM contents are a fixed function of the address; 0x1800 holds 0x5A.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h42;
  endfunction

  // VRAM device: one-cycle read latency, written only by the DUT.
  logic [7:0] vram [0:65535];
  bit         wr_vld [0:65535];
  always @(posedge clk) begin
    mem_rdata <= wr_vld[mem_addr] ? vram[mem_addr] : init_val(mem_addr);
    if (mem_we) begin
      vram[mem_addr]   <= mem_wdata;
      wr_vld[mem_addr] <= 1'b1;
    end
  end

  logic [7:0] ref_mem [0:65535];

  typedef struct {int due; logic rd; logic [7:0] data;} exp_t;
  exp_t spr_q[$];
  exp_t cpu_q[$];

  bit          a_req, a_we;
  logic [15:0] a_addr;
  logic [7:0]  a_wdata;
  int          a_wait;
  bit          m_granted;
  int          m_starve;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic start_cpu(input bit we, input logic [15:0] addr, input logic [7:0] wd);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_wait = 0; m_granted = 1'b0;
  endtask

  // One clock: drive inputs, predict the winner from the rules, check at the falling edge.
  task automatic step(input bit t, input logic [15:0] ta, input bit s, input logic [15:0] sa);
    bit elig; int win; logic [15:0] e_addr; bit e_we; exp_t e;
    @(posedge clk); #1;
    tile_active = t; tile_addr = ta; spr_req = s; spr_addr = sa;
    cpu_req = a_req; cpu_we = a_we; cpu_addr = a_addr; cpu_wdata = a_wdata;
    elig = a_req && !m_granted;
    if (t)                            win = W_TILE;
    else if (elig && m_starve >= LIMIT) win = W_CPU;
    else if (s)                       win = W_SPR;
    else if (elig)                    win = W_CPU;
    else                              win = W_NONE;
    e_addr = (win == W_SPR) ? sa : (win == W_CPU) ? a_addr : ta;
    e_we   = (win == W_CPU) && a_we;
    if (win == W_SPR) begin
      e.due = cyc + 1; e.rd = 1'b1; e.data = ref_mem[sa];
      spr_q.push_back(e);
    end
    if (win == W_CPU) begin
      e.due = cyc + (a_we ? 1 : 2); e.rd = !a_we; e.data = ref_mem[a_addr];
      cpu_q.push_back(e);
      if (a_we) ref_mem[a_addr] = a_wdata;
      m_granted = 1'b1;
    end
    if (!a_req || win == W_CPU) m_starve = 0;
    else if (elig && win == W_SPR && m_starve < LIMIT) m_starve++;
    @(negedge clk);
    chk("spr_gnt", 32'(spr_gnt), 32'(win == W_SPR));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(a_wdata));
    chk("tile_data", 32'(tile_data), 32'(mem_rdata));
    if (a_req) begin
      a_wait++;
      if (cpu_ack) a_req = 1'b0;
      else if (a_wait > 200) begin
        chk("cpu_timeout", 32'(a_wait), 32'd0);
        a_req = 1'b0;
        cpu_q.delete();
      end
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_spr_gnt", 32'(spr_gnt), 32'd0);
    chk("rst_spr_rvalid", 32'(spr_rvalid), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_spr_rdata", 32'(spr_rdata), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'd0);
    chk("rst_cnt", 32'(dut.r_cnt), 32'd0);
    chk("rst_owner", 32'(dut.r_owner), 32'd0);
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents data or one falls due.
  exp_t mon_e;
  bit   mon_exp;
  always @(negedge clk) begin
    if (!reset) begin
      mon_exp = (spr_q.size() > 0) && (spr_q[0].due <= cyc);
      if (spr_rvalid || mon_exp) begin
        chk("spr_rvalid", 32'(spr_rvalid), 32'(mon_exp));
        if (spr_q.size() > 0) begin
          mon_e = spr_q.pop_front();
          if (spr_rvalid && mon_exp) chk("spr_rdata", 32'(spr_rdata), 32'(mon_e.data));
        end
      end
      mon_exp = (cpu_q.size() > 0) && (cpu_q[0].due <= cyc);
      if (cpu_ack || mon_exp) begin
        chk("cpu_ack", 32'(cpu_ack), 32'(mon_exp));
        if (cpu_q.size() > 0) begin
          mon_e = cpu_q.pop_front();
          if (cpu_ack && mon_exp && mon_e.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gnts, sp;
    logic [7:0] exp_rd;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_wait = 0;
    m_granted = 1'b0; m_starve = 0;

    // Reset state, with a CPU write pending to show mem_we stays low.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;

    // Tile fetcher read.
    step(1'b1, 16'h1800, 1'b0, 16'h0);
    chk("tile_mem_addr", 32'(mem_addr), 32'h1800);
    chk("tile_mem_we", 32'(mem_we), 32'd0);
    step(1'b0, 16'h0203, 1'b0, 16'h0);
    chk("tile_data_5a", 32'(tile_data), 32'h5A);

    // Sprite read while idle.
    step(1'b0, 16'h0, 1'b1, 16'h2AC0);
    chk("spr_gnt_idle", 32'(spr_gnt), 32'd1);
    step(1'b0, 16'h0, 1'b0, 16'h0);
    chk("spr_rvalid_next", 32'(spr_rvalid), 32'd1);
    chk("spr_rdata_eq_mem", 32'(spr_rdata), 32'(mem_rdata));

    // CPU write deferred behind five tile cycles.
    start_cpu(1'b1, 16'h0010, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'(16'h0800 + i), 1'b0, 16'h0);
      chk("wr_deferred_we", 32'(mem_we), 32'd0);
    end
    step(1'b0, 16'h0900, 1'b0, 16'h0);
    chk("wr_free_we", 32'(mem_we), 32'd1);
    chk("wr_free_addr", 32'(mem_addr), 32'h0010);
    chk("wr_free_data", 32'(mem_wdata), 32'h3C);
    step(1'b0, 16'h0900, 1'b0, 16'h0);
    chk("wr_ack", 32'(cpu_ack), 32'd1);
    step(1'b0, 16'h0900, 1'b0, 16'h0);

    // Starvation: continuous sprite traffic against a CPU read.
    exp_rd = ref_mem[16'h0420];
    start_cpu(1'b0, 16'h0420, 8'h00);
    gnts = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 16'h0, 1'b1, 16'(16'h3000 + i));
      if (spr_gnt) gnts++;
      else break;
    end
    chk("starve_spr_gnts", 32'(gnts), 32'(LIMIT));
    chk("starve_cpu_addr", 32'(mem_addr), 32'h0420);
    step(1'b0, 16'h0, 1'b1, 16'h3100);
    chk("starve_no_early_ack", 32'(cpu_ack), 32'd0);
    step(1'b0, 16'h0, 1'b1, 16'h3101);
    chk("starve_ack", 32'(cpu_ack), 32'd1);
    chk("starve_rdata", 32'(cpu_rdata), 32'(exp_rd));
    chk("starve_cnt_clear", 32'(dut.r_cnt), 32'd0);
    step(1'b0, 16'h0, 1'b0, 16'h0);

    // Reset while the CPU read sits in RDATA.
    start_cpu(1'b0, 16'h0777, 8'h00);
    step(1'b0, 16'h0, 1'b0, 16'h0);
    @(posedge clk); #1;
    reset = 1'b1; a_req = 1'b0; cpu_req = 1'b0;
    spr_q.delete(); cpu_q.delete(); m_starve = 0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_no_ack", 32'(cpu_ack), 32'd0);
    chk("rst_mid_state", 32'(dut.r_state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    start_cpu(1'b0, 16'h0777, 8'h00);
    repeat (4) step(1'b0, 16'h0, 1'b0, 16'h0);

    // All three requesters together: only the tile fetcher is served.
    start_cpu(1'b1, 16'h0055, 8'hA5);
    step(1'b1, 16'h0300, 1'b1, 16'h3000);
    chk("all3_spr_gnt", 32'(spr_gnt), 32'd0);
    chk("all3_mem_addr", 32'(mem_addr), 32'h0300);
    chk("all3_mem_we", 32'(mem_we), 32'd0);
    step(1'b0, 16'h0, 1'b0, 16'h0);
    chk("all3_no_ack", 32'(cpu_ack), 32'd0);
    chk("all3_no_rvalid", 32'(spr_rvalid), 32'd0);
    repeat (3) step(1'b0, 16'h0, 1'b0, 16'h0);

    // Randomized traffic with varying sprite pressure.
    for (int blk = 0; blk < 6; blk++) begin
      sp = (blk % 3 == 0) ? 30 : (blk % 3 == 1) ? 70 : 100;
      for (int i = 0; i < 250; i++) begin
        if (!a_req && $urandom_range(0, 2) == 0)
          start_cpu(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 8'($urandom));
        step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 99) < sp,
             16'($urandom_range(0, 63)));
      end
    end
    for (int i = 0; i < 40 && a_req; i++) step(1'b0, 16'h0, 1'b0, 16'h0);
    repeat (4) step(1'b0, 16'h0, 1'b0, 16'h0);
    chk("spr_q_drained", 32'(spr_q.size()), 32'd0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
